alu_sequencer: RTL and testbench

Command-driven initiator for the team's 4-bit combinational ALU.
- Accepts register-to-register or load-immediate commands over a valid/ready interface.
- Reads operands from a small internal register file and drives the ALU's operand/select inputs.
- Captures the ALU result and Zero flag, writes the result back, and returns a response over a second valid/ready interface.
- Sits between a host/test controller and the ALU instance.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state type and opcode legality helper
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, all entries cleared by asynchronous active-low reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned RIDX = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RIDX-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RIDX-1:0]  raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [RIDX-1:0]  raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for an external combinational ALU: latches a
// command, runs it through the ALU or loads an immediate, writes back, responds.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned RIDX = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [RIDX-1:0]  cmd_rd,
  input  logic [RIDX-1:0]  cmd_ra,
  input  logic [RIDX-1:0]  cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       op_count
);

  seq_state_t       state_q;
  logic             load_q;
  logic [2:0]       op_q;
  logic [RIDX-1:0]  rd_q;
  logic [RIDX-1:0]  ra_q;
  logic [RIDX-1:0]  rb_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             legal;
  logic             exec_alu;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .raddr_a (ra_q),
    .rdata_a (rdata_a),
    .raddr_b (rb_q),
    .rdata_b (rdata_b)
  );

  always_comb begin
    legal     = op_legal(op_q);
    exec_alu  = (state_q == EXEC) && !load_q;
    alu_a     = exec_alu ? rdata_a : '0;
    alu_b     = exec_alu ? rdata_b : '0;
    alu_sel   = exec_alu ? op_q    : '0;
    rf_we     = (state_q == EXEC) && (load_q || legal);
    rf_wdata  = load_q ? imm_q : alu_y;
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            load_q  <= cmd_load;
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            ra_q    <= cmd_ra;
            rb_q    <= cmd_rb;
            imm_q   <= cmd_imm;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (load_q) begin
            rsp_data <= imm_q;
            rsp_zero <= (imm_q == '0);
            rsp_err  <= 1'b0;
          end else if (legal) begin
            rsp_data <= alu_y;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
            if (!rsp_err && (op_count != '1)) begin
              op_count <= op_count + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes model-predicted responses,
// a monitor pops and compares them on every response handshake.
module tb_alu_sequencer;

  typedef struct packed {
    logic [3:0] data;
    logic       zero;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [3:0] rsp_data;
  logic [7:0] op_count;

  int   total = 0;
  int   bad   = 0;
  rsp_t exp_q[$];
  logic [3:0] mrf [4];
  int   mcnt;
  bit   bp   = 0;
  bit   hold = 0;

  alu_sequencer #(.WIDTH(4), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU stand-in; unused opcodes yield a nonzero junk value.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = ~alu_a;
      default: alu_y = 4'h9;
    endcase
    alu_zero = (alu_y == 4'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 4'h0;
    mcnt = 0;
  endtask

  task automatic model_run(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic [3:0] imm, output rsp_t e);
    int a, b, y;
    a = int'(mrf[ra]);
    b = int'(mrf[rb]);
    e.err = 1'b0;
    if (ld) y = int'(imm);
    else if (op == 3'd0) y = (a + b) % 16;
    else if (op == 3'd1) y = (a - b + 16) % 16;
    else if (op == 3'd2) y = a & b;
    else if (op == 3'd3) y = a | b;
    else if (op == 3'd4) y = 15 - a;
    else begin
      y = 0;
      e.err = 1'b1;
    end
    e.data = 4'(y);
    e.zero = (y == 0);
    if (!e.err) begin
      mrf[rd] = 4'(y);
      if (mcnt < 255) mcnt++;
    end
  endtask

  task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb,
                       input logic [3:0] imm, output rsp_t e);
    int n;
    logic [3:0] a_pre, b_pre;
    e = '0;
    @(posedge clk); #1;
    cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    a_pre = mrf[ra];
    b_pre = mrf[rb];
    model_run(ld, op, rd, ra, rb, imm, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_rd = 2'($urandom);
    cmd_ra = 2'($urandom); cmd_rb = 2'($urandom); cmd_imm = 4'($urandom);
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("exec_alu_a", 32'(alu_a), ld ? 32'd0 : 32'(a_pre));
    chk("exec_alu_b", 32'(alu_b), ld ? 32'd0 : 32'(b_pre));
    chk("exec_alu_sel", 32'(alu_sel), ld ? 32'd0 : 32'(op));
    @(negedge clk);
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Response-ready driver: always ready, random backpressure, or held low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold) rsp_ready = 1'b0;
      else if (bp) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = 1'b1;
    end
  end

  // Monitor: every response handshake must match the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_err",  32'(rsp_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsp_t e;
    int   c;
    logic [2:0] rop;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0;
    cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
    model_reset();
    #23;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    chk("rst_alu_b",     32'(alu_b),     32'd0);
    chk("rst_alu_sel",   32'(alu_sel),   32'd0);
    chk("rst_op_count",  32'(op_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: loads, ADD, SUB to zero, SUB wrap.
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, e);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, e);
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, e);
    wait_idle();
    chk("add_op_count", 32'(op_count), 32'(mcnt));
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3, e);
    issue(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 4'd0, e);
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd2, e);
    issue(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 4'd0, e);

    // Illegal opcode: no writeback, no count, then read rd back via OR.
    wait_idle();
    c = mcnt;
    issue(1'b0, 3'b110, 2'd3, 2'd0, 2'd1, 4'd0, e);
    wait_idle();
    chk("illegal_op_count", 32'(op_count), 32'(c));
    issue(1'b0, 3'd3, 2'd3, 2'd3, 2'd3, 4'd0, e);

    // NOT of 4'hA.
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'hA, e);
    issue(1'b0, 3'd4, 2'd2, 2'd1, 2'd0, 4'd0, e);

    // Backpressure hold: response stable, commands ignored, also in handshake cycle.
    wait_idle();
    @(negedge clk);
    hold = 1;
    issue(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0, e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 2'($urandom); cmd_imm = 4'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data",  32'(rsp_data),  32'(e.data));
      chk("hold_rsp_zero",  32'(rsp_zero),  32'(e.zero));
      chk("hold_rsp_err",   32'(rsp_err),   32'(e.err));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    hold = 0;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Randomized commands with random backpressure.
    bp = 1;
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      issue($urandom_range(0, 3) == 0, rop, 2'($urandom), 2'($urandom), 2'($urandom),
            4'($urandom), e);
    end
    wait_idle();
    bp = 0;
    chk("rand_op_count", 32'(op_count), 32'(mcnt));

    // Asynchronous reset in the middle of EXEC abandons the ADD.
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd7, e);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd2, e);
    wait_idle();
    @(posedge clk); #1;
    cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd1; cmd_ra = 2'd0; cmd_rb = 2'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_exec_alu_a", 32'(alu_a), 32'd7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_alu_a",     32'(alu_a),     32'd0);
    chk("abort_alu_sel",   32'(alu_sel),   32'd0);
    chk("abort_rsp_data",  32'(rsp_data),  32'd0);
    chk("abort_op_count",  32'(op_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    issue(1'b0, 3'd3, 2'd1, 2'd1, 2'd1, 4'd0, e);

    // 260 loads: counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      issue(1'b1, 3'd0, 2'($urandom), 2'd0, 2'd0, 4'($urandom), e);
    end
    wait_idle();
    chk("sat_op_count", 32'(op_count), 32'd255);
    chk("sat_model_count", 32'(op_count), 32'(mcnt));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
